cpu_clk_ctrl: RTL and testbench

- Run/halt/single-step controller for the CPU core clock.
- Generates a one-cycle clock-enable pulse (`clk_en`) every DIV board-clock cycles while running.
- Emits exactly one pulse per step request while halted.
- Stops on a CPU halt request; the divide ratio is runtime-loadable.
- Sits between board switches/buttons, the CPU halt signal, and every CPU register's enable input. It also drives a visible toggling clock (`clk_out`) for an LED.

---
 rtl/cpu_clk_ctrl.sv | 146 ++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step controller for the CPU core clock.
// Issues a registered clk_en pulse every r_div board cycles while running.
module cpu_clk_ctrl #(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 4,
  parameter int          PCNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              halt_req,
  input  logic              div_load,
  input  logic [CNT_W-1:0]  div_value,
  output logic              clk_en,
  output logic              clk_out,
  output logic [1:0]        state,
  output logic              cpu_halted,
  output logic [PCNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10
  } st_t;

  st_t               r_state;
  st_t               w_next;
  logic [CNT_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_step_q;
  logic              r_clk_en;
  logic              r_clk_out;
  logic              r_halted;
  logic [PCNT_W-1:0] r_pcnt;

  logic w_edge;
  logic w_tc;
  logic w_pulse;
  logic w_cnt_clr;
  logic w_set_halt;
  logic w_clr_halt;

  assign w_edge = step_btn & ~r_step_q;
  assign w_tc   = (r_cnt == r_div - CNT_W'(1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_HALT;
    else       r_state <= w_next;
  end

  // next-state logic; halt_req outranks every other event
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HALT: begin
        if (!halt_req && run_sw && !r_halted)
          w_next = S_RUN;
        else if (!halt_req && w_edge)
          w_next = S_STEP;
      end
      S_RUN: begin
        if (halt_req || !run_sw)
          w_next = S_HALT;
      end
      S_STEP: begin
        if (halt_req)
          w_next = S_HALT;
        else if (w_tc && !div_load)
          w_next = S_HALT;
      end
      default: w_next = S_HALT;
    endcase
  end

  // per-state controls for the counter, pulse and halt flag
  always_comb begin
    w_pulse    = 1'b0;
    w_cnt_clr  = 1'b1;
    w_set_halt = 1'b0;
    w_clr_halt = 1'b0;
    unique case (r_state)
      S_HALT: begin
        w_clr_halt = ~run_sw;
      end
      S_RUN: begin
        if (halt_req) begin
          w_set_halt = 1'b1;
        end else if (run_sw) begin
          w_pulse   = w_tc & ~div_load;
          w_cnt_clr = w_tc;
        end
      end
      S_STEP: begin
        if (halt_req) begin
          w_set_halt = 1'b1;
        end else begin
          w_pulse   = w_tc & ~div_load;
          w_cnt_clr = w_tc;
        end
      end
      default: begin
        w_pulse = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= CNT_W'(DEFAULT_DIV);
      r_cnt     <= '0;
      r_step_q  <= 1'b0;
      r_clk_en  <= 1'b0;
      r_clk_out <= 1'b0;
      r_halted  <= 1'b0;
      r_pcnt    <= '0;
    end else begin
      r_step_q <= step_btn;
      r_clk_en <= w_pulse;
      if (w_pulse) begin
        r_clk_out <= ~r_clk_out;
        r_pcnt    <= r_pcnt + PCNT_W'(1);
      end
      if (w_set_halt)      r_halted <= 1'b1;
      else if (w_clr_halt) r_halted <= 1'b0;
      // a load restarts the count, which also swallows a coincident pulse
      if (div_load) begin
        r_div <= (div_value == '0) ? CNT_W'(1) : div_value;
        r_cnt <= '0;
      end else if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign clk_en     = r_clk_en;
  assign clk_out    = r_clk_out;
  assign state      = r_state;
  assign cpu_halted = r_halted;
  assign pulse_cnt  = r_pcnt;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed scenarios plus random traffic,
// every cycle compared against a cycle-age reference model.
module tb_cpu_clk_ctrl;

  logic        clk;
  logic        reset;
  logic        run_sw;
  logic        step_btn;
  logic        halt_req;
  logic        div_load;
  logic [31:0] div_value;
  logic        clk_en;
  logic        clk_out;
  logic [1:0]  state;
  logic        cpu_halted;
  logic [15:0] pulse_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  // reference model: mode, divide ratio and cycles elapsed since restart
  logic [1:0] m_mode;
  longint     m_div;
  longint     m_age;
  bit         m_en, m_out, m_hlt, m_prev;
  int         m_pc;

  cpu_clk_ctrl #(
    .CNT_W(32), .DEFAULT_DIV(4), .PCNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .run_sw(run_sw),
    .step_btn(step_btn), .halt_req(halt_req),
    .div_load(div_load), .div_value(div_value),
    .clk_en(clk_en), .clk_out(clk_out), .state(state),
    .cpu_halted(cpu_halted), .pulse_cnt(pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit edge_s, fire, due;
    if (reset) begin
      m_mode = 2'b00; m_div = 4; m_age = 0;
      m_en = 0; m_out = 0; m_hlt = 0; m_pc = 0; m_prev = 0;
      return;
    end
    edge_s = step_btn && !m_prev;
    m_prev = step_btn;
    fire   = 0;
    if (m_mode == 2'b00) begin
      m_age = 0;
      if (!halt_req && run_sw && !m_hlt) m_mode = 2'b01;
      else if (!halt_req && edge_s)      m_mode = 2'b10;
      if (!run_sw) m_hlt = 0;
    end else if (halt_req) begin
      m_mode = 2'b00; m_hlt = 1; m_age = 0;
    end else if (m_mode == 2'b01 && !run_sw) begin
      m_mode = 2'b00; m_age = 0;
    end else begin
      due  = ((m_age % m_div) == m_div - 1) && !div_load;
      fire = due;
      m_age++;
      if (due && m_mode == 2'b10) begin
        m_mode = 2'b00; m_age = 0;
      end
    end
    if (div_load) begin
      m_div = (div_value == 0) ? 1 : longint'(div_value);
      m_age = 0;
    end
    m_en = fire;
    if (fire) begin
      m_pc  = (m_pc + 1) % 65536;
      m_out = !m_out;
    end
  endtask

  task automatic cyc();
    logic [20:0] exp_v;
    @(posedge clk);
    model_step();
    #1;
    exp_v = {m_mode, m_hlt, m_en, m_out, 16'(m_pc)};
    chk("outs", {11'd0, state, cpu_halted, clk_en, clk_out, pulse_cnt},
        {11'd0, exp_v});
  endtask

  initial begin
    int lat, g, np, n;
    bit seen;
    reset = 1; run_sw = 0; step_btn = 0; halt_req = 0;
    div_load = 0; div_value = '0;

    // reset and free-run at the default ratio
    cyc(); cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_pcnt", 32'(pulse_cnt), 0);
    chk("rst_clkout", 32'(clk_out), 0);
    reset = 0; run_sw = 1;
    cyc();
    chk("run_entered", 32'(state), 1);
    lat = 0;
    do begin cyc(); lat++; end while (!clk_en && lat < 50);
    chk("first_lat", lat, 4);
    for (int p = 0; p < 4; p++) begin
      g = 0;
      do begin cyc(); g++; end while (!clk_en && g < 50);
      chk("period4", g, 4);
    end
    chk("pcnt5", 32'(pulse_cnt), 5);
    chk("clkout5", 32'(clk_out), 1);

    // single step, held button gives one pulse
    run_sw = 0; cyc();
    reset = 1; cyc();
    reset = 0; cyc();
    for (int k = 0; k < 2; k++) begin
      step_btn = 1; np = 0; seen = 0;
      repeat (20) begin
        cyc();
        if (state == 2'b10) seen = 1;
        np += int'(clk_en);
      end
      chk("step_pulses", np, 1);
      chk("step_seen", 32'(seen), 1);
      chk("step_halt", 32'(state), 0);
      chk("step_pcnt", 32'(pulse_cnt), k + 1);
      step_btn = 0; cyc(); cyc();
    end

    // halt_req on terminal count at div 3
    div_value = 3; div_load = 1; cyc();
    div_load = 0; run_sw = 1; cyc();
    n = 0;
    while (!(m_mode == 2'b01 && (m_age % m_div) == m_div - 1) && n < 20) begin
      cyc(); n++;
    end
    halt_req = 1; cyc();
    halt_req = 0;
    chk("hq_no_pulse", 32'(clk_en), 0);
    chk("hq_state", 32'(state), 0);
    chk("hq_halted", 32'(cpu_halted), 1);
    repeat (5) cyc();
    chk("hq_stays", 32'(state), 0);
    run_sw = 0; cyc();
    chk("rearm", 32'(cpu_halted), 0);
    run_sw = 1; cyc();
    chk("resume", 32'(state), 1);

    // runtime divide loads: 0 maps to 1, then 7
    repeat (4) cyc();
    div_value = 0; div_load = 1; cyc();
    div_load = 0;
    chk("load_supp", 32'(clk_en), 0);
    np = 0;
    repeat (6) begin cyc(); np += int'(clk_en); end
    chk("div1_every", np, 6);
    div_value = 7; div_load = 1; cyc();
    div_load = 0;
    for (int p = 0; p < 2; p++) begin
      g = 0;
      do begin cyc(); g++; end while (!clk_en && g < 50);
      chk("period7", g, 7);
    end

    // reset in the middle of a step
    run_sw = 0; reset = 1; cyc();
    reset = 0; cyc();
    step_btn = 1; cyc();
    cyc(); cyc();
    chk("mid_step", 32'(state), 2);
    reset = 1; step_btn = 0; cyc();
    reset = 0;
    chk("rst_vec", {11'd0, state, cpu_halted, clk_en, clk_out, pulse_cnt}, 0);
    np = 0;
    repeat (10) begin cyc(); np += int'(clk_en); end
    chk("no_pulse_after_rst", np, 0);

    // pulse counter wrap at div 1
    div_value = 1; div_load = 1; cyc();
    div_load = 0; run_sw = 1;
    np = 0; n = 0;
    while (np < 65536 && n < 70000) begin
      cyc(); np += int'(clk_en); n++;
    end
    chk("wrap_reached", np, 65536);
    chk("wrap_pcnt", 32'(pulse_cnt), 0);
    chk("wrap_clkout", 32'(clk_out), 0);
    run_sw = 0; cyc();

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom % 200) == 0;
      if (($urandom % 30) == 0) run_sw = ~run_sw;
      if (($urandom % 5) == 0)  step_btn = ~step_btn;
      halt_req  = ($urandom % 25) == 0;
      div_load  = ($urandom % 40) == 0;
      div_value = $urandom % 6;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
